// File: rtl/t_bank_count_ctrl.sv
// t_bank_count_ctrl
// Sequences a bank of T flip-flops (q <= q ^ t_vec) as a programmable
// up/down counter with parallel load, run-to-limit, abort and done pulse.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start, dir      begin a run (IDLE only); direction 1=up 0=down
//   limit           terminal value, sampled with start
//   load, load_val  parallel load through toggles (IDLE only, beats start)
//   abort           end a run immediately, q frozen (RUN only)
//   t_vec           toggle enables applied this cycle (combinational)
//   q, qb           bank state and its complement
//   busy, done      high in RUN; high for the single DONE cycle
module t_bank_count_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             abort,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             dir_r;
    logic [WIDTH-1:0] limit_r;
    logic             capture;
    logic [WIDTH-1:0] step_vec;

    // Ripple toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down)
    always_comb begin
        logic carry;
        carry    = 1'b1;
        step_vec = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            step_vec[i] = carry;
            carry       = carry & (dir_r ? q[i] : ~q[i]);
        end
    end

    // Next-state and toggle decode
    always_comb begin
        state_nxt = state;
        t_vec     = '0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (load) begin
                    t_vec = q ^ load_val;
                end else if (start) begin
                    capture   = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (q == limit_r) begin
                    state_nxt = S_DONE;
                end else begin
                    t_vec = step_vec;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, bank and run parameters; busy/done registered from next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            q       <= '0;
            dir_r   <= 1'b0;
            limit_r <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            q     <= q ^ t_vec;
            busy  <= (state_nxt == S_RUN);
            done  <= (state_nxt == S_DONE);
            if (capture) begin
                dir_r   <= dir;
                limit_r <= limit;
            end
        end
    end

    assign qb = ~q;

endmodule

// File: tb/tb_t_bank_count_ctrl.sv
module tb_t_bank_count_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       dir;
    logic [3:0] limit;
    logic       load;
    logic [3:0] load_val;
    logic       abort;
    logic [3:0] t_vec;
    logic [3:0] q;
    logic [3:0] qb;
    logic       busy;
    logic       done;

    int checks;
    int failures;

    logic [3:0] exp_steps[$];
    int         exp_busy[$];
    logic [3:0] model_q;

    t_bank_count_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .limit(limit),
        .load(load), .load_val(load_val), .abort(abort),
        .t_vec(t_vec), .q(q), .qb(qb), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] val, input logic with_start);
        load     = 1'b1;
        load_val = val;
        start    = with_start;
        limit    = 4'd0;
        dir      = 1'b1;
        tick();
        load  = 1'b0;
        start = 1'b0;
        model_q = val;
        checks++;
        if (q !== val) begin
            failures++;
            $display("FAIL load_q: got %h expected %h", q, val);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL load_busy: got %b expected 0", busy);
        end
    endtask

    // Start a run, push the model's step sequence, then follow it to completion
    task automatic do_run(input logic d, input logic [3:0] lim,
                          input logic chk_en, input logic [3:0] chk_q, input logic [3:0] chk_t);
        logic [3:0] n;
        logic [3:0] prev;
        logic [3:0] e;
        int bc;
        int dc;
        int eb;
        bit seen;
        n = d ? 4'(lim - model_q) : 4'(model_q - lim);
        for (int i = 1; i <= int'(n); i++)
            exp_steps.push_back(d ? 4'(model_q + 4'(i)) : 4'(model_q - 4'(i)));
        exp_busy.push_back(int'(n) + 1);
        start = 1'b1;
        dir   = d;
        limit = lim;
        tick();
        start = 1'b0;
        dir   = ~d;
        limit = ~lim;
        bc = 0;
        dc = 0;
        seen = 0;
        for (int c = 0; c < 64; c++) begin
            if (busy) bc++;
            if (done) begin
                dc++;
                seen = 1;
            end else if (seen) begin
                break;
            end
            if (chk_en && busy && q == chk_q) begin
                checks++;
                if (t_vec !== chk_t) begin
                    failures++;
                    $display("FAIL t_vec_at_%h: got %b expected %b", chk_q, t_vec, chk_t);
                end
            end
            prev = q;
            tick();
            if (q !== prev) begin
                checks++;
                if (exp_steps.size() == 0) begin
                    failures++;
                    $display("FAIL extra_step: got %h from %h expected no change", q, prev);
                end else begin
                    e = exp_steps.pop_front();
                    if (q !== e) begin
                        failures++;
                        $display("FAIL step: got %h expected %h", q, e);
                    end
                end
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL run_timeout: done never seen, q=%h", q);
        end
        eb = exp_busy.pop_front();
        checks++;
        if (bc !== eb) begin
            failures++;
            $display("FAIL busy_cycles: got %0d expected %0d", bc, eb);
        end
        checks++;
        if (dc !== 1) begin
            failures++;
            $display("FAIL done_cycles: got %0d expected 1", dc);
        end
        checks++;
        if (exp_steps.size() != 0 || q !== lim) begin
            failures++;
            $display("FAIL final_q: got %h expected %h (missing steps %0d)", q, lim, exp_steps.size());
        end
        exp_steps.delete();
        model_q = lim;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; dir = 1'b0; limit = 4'd0; load = 1'b0; load_val = 4'd0; abort = 1'b0;
        #12;
        checks++;
        if ({q, qb, t_vec, busy, done} !== {4'h0, 4'hF, 4'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs: got q=%h qb=%h t=%h busy=%b done=%b expected 0 F 0 0 0",
                     q, qb, t_vec, busy, done);
        end
        rst = 1'b0;
        model_q = 4'd0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (q !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: got q=%h busy=%b done=%b expected 0 0 0", q, busy, done);
        end
    endtask

    task automatic test_count_up();
        do_load(4'd3, 1'b0);
        do_run(1'b1, 4'd7, 1'b1, 4'd3, 4'b0111);
    endtask

    task automatic test_count_down_wrap();
        do_load(4'd1, 1'b0);
        do_run(1'b0, 4'd14, 1'b1, 4'd0, 4'b1111);
    endtask

    task automatic test_abort();
        int guard;
        int dn;
        do_load(4'd0, 1'b0);
        start = 1'b1; dir = 1'b1; limit = 4'd12;
        tick();
        start = 1'b0;
        guard = 0;
        while (q !== 4'd5 && guard < 40) begin
            tick();
            guard++;
        end
        checks++;
        if (q !== 4'd5 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_reach5: got q=%h busy=%b expected 5 1", q, busy);
        end
        abort = 1'b1;
        #1;
        checks++;
        if (t_vec !== 4'h0) begin
            failures++;
            $display("FAIL abort_tvec: got %b expected 0000", t_vec);
        end
        tick();
        abort = 1'b0;
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) dn++;
            tick();
        end
        checks++;
        if (q !== 4'd5 || busy !== 1'b0 || dn !== 0) begin
            failures++;
            $display("FAIL abort_hold: got q=%h busy=%b done_cycles=%0d expected 5 0 0", q, busy, dn);
        end
        model_q = 4'd5;
        do_run(1'b1, 4'd6, 1'b0, 4'd0, 4'd0);
    endtask

    task automatic test_load_start_same_cycle();
        do_load(4'd9, 1'b1);
        tick();
        checks++;
        if (busy !== 1'b0 || q !== 4'd9) begin
            failures++;
            $display("FAIL load_beats_start: got q=%h busy=%b expected 9 0", q, busy);
        end
        do_run(1'b0, 4'd9, 1'b0, 4'd0, 4'd0);
    endtask

    task automatic test_reset_mid_run();
        int guard;
        do_load(4'd0, 1'b0);
        start = 1'b1; dir = 1'b1; limit = 4'd15;
        tick();
        start = 1'b0;
        guard = 0;
        while (q !== 4'd6 && guard < 40) begin
            tick();
            guard++;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got q=%h busy=%b done=%b expected 0 0 0", q, busy, done);
        end
        #2;
        rst = 1'b0;
        model_q = 4'd0;
        tick();
        do_run(1'b1, 4'd2, 1'b1, 4'd1, 4'b0011);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_count_up();
        test_count_down_wrap();
        test_abort();
        test_load_start_same_cycle();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/t_bank_count_ctrl.md
# t_bank_count_ctrl

Controller that sequences a bank of T flip-flops (each a D flop with `d = q ^ t`) as a programmable up/down counter. It generates the per-bit toggle enables, supports a parallel load, and runs the bank from its current value to a programmed limit. It signals `busy` while running and a one-cycle `done` on arrival. It sits between a host/test FSM and the toggle-flop datapath, and it owns the bank's state.

## Interface
Parameters:
- `WIDTH`, 4, number of T flip-flops in the bank (≥2)

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a run (accepted only in IDLE)
- `dir`  in  1  1 = count up, 0 = count down; sampled with `start`
- `limit`  in  WIDTH  terminal value; sampled with `start`
- `load`  in  1  parallel load request (accepted in IDLE only)
- `load_val`  in  WIDTH  value to load
- `abort`  in  1  terminate a run (RUN only)
- `t_vec`  out  WIDTH  toggle enables applied to the bank this cycle (combinational)
- `q`  out  WIDTH  bank state
- `qb`  out  WIDTH  `~q`
- `busy`  out  1  high in RUN
- `done`  out  1  high for the single DONE cycle

## Operation
- Bank update every edge: `q <= q ^ t_vec`. There is no other write path into `q`; loads also go through toggles.
- States: IDLE, RUN, DONE. Registers: state, `q`, `dir_r`, `limit_r`.
- Reset (async, immediate): state = IDLE, `q` = 0, `dir_r` = 0, `limit_r` = 0. Outputs: `t_vec` = 0, `qb` = all ones, `busy` = 0, `done` = 0.
- IDLE:
  - `load`=1: `t_vec = q ^ load_val`, so `q = load_val` after the edge; stay in IDLE.
  - `load`=0 and `start`=1: `dir_r <= dir`, `limit_r <= limit`, go to RUN; `t_vec` = 0.
  - `load` and `start` together: load wins and `start` is dropped.
  - `abort` is ignored.
  - Otherwise `t_vec` = 0.
- RUN:
  - `abort`=1: `t_vec` = 0, go to IDLE; `q` holds. Abort has priority over the limit check.
  - `q == limit_r`: `t_vec` = 0, go to DONE.
  - Otherwise step:
    - Up: `t_vec[0]=1`, `t_vec[i] = &q[i-1:0]`.
    - Down: `t_vec[0]=1`, `t_vec[i] = &~q[i-1:0]`.
  - `start`, `load`, `dir`, `limit` are ignored in RUN.
- DONE: `t_vec` = 0, `done` = 1, unconditional return to IDLE. `start` and `load` are ignored in this cycle.
- Arithmetic is modulo 2^WIDTH. Up wraps from all-ones to 0; down wraps from 0 to all-ones. A run always reaches `limit_r` through the wrap if needed.
- `busy` and `done` are Moore decodes of state.

## Timing
- `start` sampled at edge k → RUN from edge k. The first step lands at edge k+1.
- Steps from start value a: n = (L−a) mod 2^W for up, (a−L) mod 2^W for down. `q == L` after edge k+n.
- RUN lasts n+1 cycles (`busy` high for n+1 cycles). DONE occupies edge k+n+1 to k+n+2, then IDLE.
- Start with `q == limit` already: n = 0, one RUN cycle, then DONE. There is no full wrap.
- Load takes effect one edge after it is sampled. `start` is first accepted in the cycle after a load.
- Abort sampled at edge j: IDLE from edge j, with `q` frozen at its edge-j value. `done` does not pulse.
- Reset asserted mid-RUN: immediate IDLE with `q` = 0. No `done` pulse.

## Test plan
- Reset, then release: `q`=0, `qb`=4'hF, `busy`=0, `done`=0, `t_vec`=0. Hold `start`=0 for 5 cycles → `q` stays 0.
- `load` 3, then `start` with up and `limit` 7 → `q` goes 3,4,5,6,7 on successive edges. `busy` is high for 5 cycles, `done` is high for 1 cycle, final `q`=7. At 3→4, `t_vec`=4'b0111.
- `load` 1, then `start` with down and `limit` 14 → `q` goes 1,0,15,14. `t_vec` at 0→15 is 4'b1111. `done` pulses once.
- Run up from 0 to limit 12, `abort` pulsed when `q`=5 → `q` holds 5, state is IDLE, no `done`. A later `start` with limit 6 reaches 6 with `busy` high for 2 cycles.
- `load`=1 with `load_val` 9 and `start`=1 in the same cycle → `q`=9, `busy` stays 0. `start` with `limit` 9 → 1 RUN cycle, then `done`, `q`=9.
- Run up from 0 to limit 15; assert `rst` asynchronously when `q`=6 → `q`=0 and `busy`=0 before the next edge. Release and rerun to limit 2 → normal completion.
